// File: rtl/matrix_mult_transpose_if.sv
// matrix_mult_transpose_if: start/done handshake, weight/error inputs and result bus of the transpose engine
interface matrix_mult_transpose_if #(
  parameter int dataWidth     = 8,
  parameter int NsInPrevLayer = 784,
  parameter int NsInNextLayer = 30
);
  logic                                         start;
  logic [NsInNextLayer-1:0][NsInPrevLayer-1:0]  inputWeights;
  logic [NsInNextLayer-1:0][dataWidth-1:0]      inputError;
  logic                                         busy;
  logic                                         done;
  logic [NsInPrevLayer-1:0][dataWidth-1:0]      outputError;
  modport master (output start, inputWeights, inputError, input busy, done, outputError);
  modport slave  (input start, inputWeights, inputError, output busy, done, outputError);
endinterface

// File: rtl/matrix_mult_transpose.sv
// matrix_mult_transpose: sequential transposed binary-weight matrix-vector product, one weight row per cycle
module matrix_mult_transpose #(
  parameter int dataWidth     = 8,
  parameter int NsInPrevLayer = 784,
  parameter int NsInNextLayer = 30
) (
  input  logic                    clk,
  input  logic                    rst,
  matrix_mult_transpose_if.slave  bus
);
  localparam int AW = dataWidth + $clog2(NsInNextLayer);
  localparam int RW = (NsInNextLayer > 1) ? $clog2(NsInNextLayer) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(NsInNextLayer - 1);
  localparam logic [AW-1:0] SAT_MAX  = AW'({dataWidth{1'b1}});
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t                                   state_q, state_d;
  logic [RW-1:0]                            row_q, row_d;
  logic [NsInPrevLayer-1:0][AW-1:0]         acc_q, acc_d;
  logic [NsInNextLayer-1:0][dataWidth-1:0]  err_q, err_d;
  logic [NsInPrevLayer-1:0][dataWidth-1:0]  out_q, out_d;
  logic                                     done_q, done_d;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      acc_q   <= '0;
      err_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end
  // done is registered so it rises together with the outputError update on the edge leaving DONE
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    acc_d   = acc_q;
    err_d   = err_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        err_d   = bus.inputError;
        acc_d   = '0;
        row_d   = '0;
        state_d = ACCUM;
      end
      ACCUM: begin
        for (int j = 0; j < NsInPrevLayer; j++)
          acc_d[j] = acc_q[j] + (bus.inputWeights[row_q][j] ? AW'(err_q[row_q]) : '0);
        row_d   = row_q + 1'b1;
        state_d = (row_q == LAST_ROW) ? DONE : ACCUM;
      end
      DONE: begin
        for (int j = 0; j < NsInPrevLayer; j++)
          out_d[j] = (acc_q[j] > SAT_MAX) ? {dataWidth{1'b1}} : acc_q[j][dataWidth-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.busy        = (state_q == ACCUM);
  assign bus.done        = done_q;
  assign bus.outputError = out_q;
endmodule
